// File: rtl/pipe_ctrl.sv
// Stall/flush controller: per-stage hold vector, IF/ID and ID/EX bubble strobes, PC redirect.
// Latency: lock, cleans and redirect are combinational; pending state and counters update at the next edge.
// Backpressure: the deepest stage stall wins; a branch is held in EX while EX or MEM stalls.
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [4:0]        lock_o,
    output logic              IFID_clean_o,
    output logic              IDEX_clean_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              pending_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pend_target;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic [4:0]        lock;
    logic [4:0]        ds_lock;
    logic              ifid_clean;
    logic              idex_clean;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              accept;
    logic              latch_target;
    logic              ds_stall;

    assign ds_stall = stallreq_ex | stallreq_mem;

    // Lock/clean/redirect selection and next state; reset forces every strobe low.
    always_comb begin
        lock         = 5'b00000;
        ds_lock      = 5'b00000;
        ifid_clean   = 1'b0;
        idex_clean   = 1'b0;
        redirect     = 1'b0;
        target       = '0;
        accept       = 1'b0;
        latch_target = 1'b0;
        state_nxt    = state;

        // Only EX and MEM stalls survive into PEND, so keep them apart.
        if (stallreq_mem) begin
            ds_lock = 5'b01111;
        end else if (stallreq_ex) begin
            ds_lock = 5'b00111;
        end

        if (stallreq_mem || stallreq_ex) begin
            lock = ds_lock;
        end else if (stallreq_id) begin
            lock       = 5'b00011;
            idex_clean = 1'b1;
        end else if (stallreq_if) begin
            lock       = 5'b00001;
            ifid_clean = 1'b1;
        end

        case (state)
            IDLE: begin
                if (branch_i && !ds_stall) begin
                    accept     = 1'b1;
                    ifid_clean = 1'b1;
                    idex_clean = 1'b1;
                    if (!stallreq_if) begin
                        lock     = 5'b00000;
                        redirect = 1'b1;
                        target   = branch_target_i;
                    end else begin
                        // Fetch still in flight: park the target until it lands.
                        lock         = 5'b00001;
                        latch_target = 1'b1;
                        state_nxt    = PEND;
                    end
                end
            end
            PEND: begin
                // Whatever the in-flight fetch returns is wrong-path.
                ifid_clean = 1'b1;
                idex_clean = 1'b0;
                lock       = ds_lock | {4'b0000, stallreq_if};
                if (!stallreq_if && !ds_stall) begin
                    lock      = 5'b00000;
                    redirect  = 1'b1;
                    target    = pend_target;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (rst) begin
            lock       = 5'b00000;
            ifid_clean = 1'b0;
            idex_clean = 1'b0;
            redirect   = 1'b0;
            target     = '0;
            accept     = 1'b0;
        end
    end

    // State register and parked redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend_target <= '0;
        end else begin
            state <= state_nxt;
            if (latch_target) begin
                pend_target <= branch_target_i;
            end
        end
    end

    // Saturating performance counters: PC-hold cycles and accepted redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lock[0] && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (accept && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign lock_o        = lock;
    assign IFID_clean_o  = ifid_clean;
    assign IDEX_clean_o  = idex_clean;
    assign pc_redirect_o = redirect;
    assign pc_target_o   = target;
    assign pending_o     = !rst && (state == PEND);
    assign stall_cnt_o   = rst ? '0 : stall_cnt;
    assign flush_cnt_o   = rst ? '0 : flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: scripted cycles push expected outputs, a negedge monitor pops and compares.
// Latency: one queue entry per clock cycle, checked mid-cycle.
// Backpressure: stall patterns are driven directly; a narrow-counter instance covers saturation.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_i;
    logic [31:0] branch_target_i;

    logic [4:0]  lock_o;
    logic        IFID_clean_o;
    logic        IDEX_clean_o;
    logic        pc_redirect_o;
    logic [31:0] pc_target_o;
    logic        pending_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    logic [4:0]  n_lock;
    logic        n_ifid;
    logic        n_idex;
    logic        n_redir;
    logic [31:0] n_target;
    logic        n_pending;
    logic [3:0]  n_stall_cnt;
    logic [3:0]  n_flush_cnt;

    typedef struct {
        logic [4:0]  lock;
        logic        ifid;
        logic        idex;
        logic        redir;
        logic [31:0] target;
        logic        pending;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
        logic [3:0]  stall4;
        logic [3:0]  flush4;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int errors;
    int m_stall;
    int m_flush;
    logic m_pend;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .lock_o(lock_o), .IFID_clean_o(IFID_clean_o), .IDEX_clean_o(IDEX_clean_o),
        .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o), .pending_o(pending_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Narrow counters make saturation reachable in a few cycles.
    pipe_ctrl #(.ADDR_W(32), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .lock_o(n_lock), .IFID_clean_o(n_ifid), .IDEX_clean_o(n_idex),
        .pc_redirect_o(n_redir), .pc_target_o(n_target), .pending_o(n_pending),
        .stall_cnt_o(n_stall_cnt), .flush_cnt_o(n_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    // Mid-cycle: compare every output with the entry pushed for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("lock", {59'd0, lock_o}, {59'd0, e.lock});
            check("ifid_clean", {63'd0, IFID_clean_o}, {63'd0, e.ifid});
            check("idex_clean", {63'd0, IDEX_clean_o}, {63'd0, e.idex});
            check("pc_redirect", {63'd0, pc_redirect_o}, {63'd0, e.redir});
            check("pc_target", {32'd0, pc_target_o}, {32'd0, e.target});
            check("pending", {63'd0, pending_o}, {63'd0, e.pending});
            check("stall_cnt", {32'd0, stall_cnt_o}, {32'd0, e.stall_cnt});
            check("flush_cnt", {32'd0, flush_cnt_o}, {32'd0, e.flush_cnt});
            check("stall_cnt_sat4", {60'd0, n_stall_cnt}, {60'd0, e.stall4});
            check("flush_cnt_sat4", {60'd0, n_flush_cnt}, {60'd0, e.flush4});
        end
    end

    // One clock cycle: st = {mem, ex, id, if}; expected combinational outputs given by the caller.
    task automatic cyc(input logic [3:0] st, input logic br, input logic [31:0] tgt,
                       input logic [4:0] e_lock, input logic e_ifid, input logic e_idex,
                       input logic e_redir, input logic [31:0] e_tgt,
                       input logic e_acc, input logic e_npend);
        exp_t e;
        if (m_pend && br) begin
            $display("FAIL illegal_branch_in_pend: branch_i driven while pending at %0t", $time);
            errors++;
        end
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = st;
        branch_i        = br;
        branch_target_i = tgt;
        e.lock      = e_lock;
        e.ifid      = e_ifid;
        e.idex      = e_idex;
        e.redir     = e_redir;
        e.target    = e_tgt;
        e.pending   = m_pend;
        e.stall_cnt = m_stall;
        e.flush_cnt = m_flush;
        e.stall4    = sat4(m_stall);
        e.flush4    = sat4(m_flush);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (e_lock[0]) m_stall++;
        if (e_acc) m_flush++;
        m_pend = e_npend;
    endtask

    // Reset cycles: every output is held at zero while rst is high.
    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            e = '{lock: 5'd0, ifid: 1'b0, idex: 1'b0, redir: 1'b0, target: 32'd0,
                  pending: 1'b0, stall_cnt: 32'd0, flush_cnt: 32'd0, stall4: 4'd0, flush4: 4'd0};
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        m_stall = 0;
        m_flush = 0;
        m_pend  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_stall = 0;
        m_flush = 0;
        m_pend  = 1'b0;
        rst = 1'b1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        branch_i = 1'b0;
        branch_target_i = 32'd0;
        @(posedge clk);
        #1;
        do_reset(2);

        // Stall priority table.
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b1010, 0, 32'h0,      5'b01111, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0010, 0, 32'h0,      5'b00011, 0, 1, 0, 32'h0, 0, 0);
        cyc(4'b0100, 0, 32'h0,      5'b00111, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0001, 0, 32'h0,      5'b00001, 1, 0, 0, 32'h0, 0, 0);
        cyc(4'b0111, 0, 32'h0,      5'b00111, 0, 0, 0, 32'h0, 0, 0);

        // Immediate redirect, then one with a load-use stall it overrides.
        cyc(4'b0000, 1, 32'h1040,   5'b00000, 1, 1, 1, 32'h1040, 1, 0);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0010, 1, 32'h3000,   5'b00000, 1, 1, 1, 32'h3000, 1, 0);

        // Redirect parked behind a three-cycle fetch stall.
        cyc(4'b0001, 1, 32'h2000,   5'b00001, 1, 1, 0, 32'h0, 1, 1);
        cyc(4'b0001, 0, 32'h0,      5'b00001, 1, 0, 0, 32'h0, 0, 1);
        cyc(4'b0001, 0, 32'h0,      5'b00001, 1, 0, 0, 32'h0, 0, 1);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 1, 0, 1, 32'h2000, 0, 0);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);

        // Branch held while MEM then EX stall, accepted once both clear.
        cyc(4'b1000, 1, 32'h4000,   5'b01111, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b1000, 1, 32'h4000,   5'b01111, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0100, 1, 32'h4000,   5'b00111, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0000, 1, 32'h4000,   5'b00000, 1, 1, 1, 32'h4000, 1, 0);

        // Parked redirect held by downstream stalls after the fetch lands.
        cyc(4'b0001, 1, 32'h5000,   5'b00001, 1, 1, 0, 32'h0, 1, 1);
        cyc(4'b1000, 0, 32'h0,      5'b01111, 1, 0, 0, 32'h0, 0, 1);
        cyc(4'b0101, 0, 32'h0,      5'b00111, 1, 0, 0, 32'h0, 0, 1);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 1, 0, 1, 32'h5000, 0, 0);

        // Long fetch stall: narrow stall counter must stick at all-ones.
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0001, 0, 32'h0,  5'b00001, 1, 0, 0, 32'h0, 0, 0);
        end
        // More redirects than the narrow flush counter can hold.
        for (int i = 0; i < 16; i++) begin
            cyc(4'b0000, 1, 32'h100 + 32'(i), 5'b00000, 1, 1, 1, 32'h100 + 32'(i), 1, 0);
        end
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);

        // Reset while a redirect is parked drops it.
        cyc(4'b0001, 1, 32'h6000,   5'b00001, 1, 1, 0, 32'h0, 1, 1);
        cyc(4'b0001, 0, 32'h0,      5'b00001, 1, 0, 0, 32'h0, 0, 1);
        do_reset(1);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);
        cyc(4'b0000, 0, 32'h0,      5'b00000, 0, 0, 0, 32'h0, 0, 0);

        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. Collects stall requests from IF, ID, EX and MEM and taken-branch redirects from EX. Drives the per-stage `lock` vector and the clean (bubble) strobes of the IF/ID and ID/EX registers, plus the PC redirect to the PC register. Holds a redirect that arrives while an instruction fetch is still in flight, and counts stall cycles and flushes for performance monitoring.

## Interface
Parameters:
- `ADDR_W`, 32, PC/target width
- `CNT_W`, 32, performance counter width

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  synchronous, active-high reset (`RstEnable` = 1)
- `stallreq_if`  in  1  fetch not complete this cycle
- `stallreq_id`  in  1  load-use hazard in ID
- `stallreq_ex`  in  1  multi-cycle EX operation in progress
- `stallreq_mem`  in  1  data memory access pending
- `branch_i`  in  1  EX resolved a taken branch/jump this cycle
- `branch_target_i`  in  ADDR_W  redirect target
- `lock_o`  out  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB
- `IFID_clean_o`  out  1  zero the IF/ID register at the next edge
- `IDEX_clean_o`  out  1  zero the ID/EX register at the next edge
- `pc_redirect_o`  out  1  PC loads `pc_target_o` at the next edge
- `pc_target_o`  out  ADDR_W  redirect address
- `pending_o`  out  1  redirect held (state PEND)
- `stall_cnt_o`  out  CNT_W  cycles with `lock_o[0]`=1
- `flush_cnt_o`  out  CNT_W  accepted branch redirects

## Operation
- The lock vector is combinational and selected by the deepest active stall:
  - mem: 5'b01111
  - else ex: 5'b00111
  - else id: 5'b00011, with `IDEX_clean_o`=1 (bubble into EX)
  - else if: 5'b00001, with `IFID_clean_o`=1 (bubble into ID)
  - else: 5'b00000
- Branch acceptance: `branch_i` is honoured only when `stallreq_ex`=0 and `stallreq_mem`=0. Otherwise EX is held and the branch re-presents on a later cycle.
- State IDLE, accepted branch with `stallreq_if`=0:
  - `pc_redirect_o`=1, `pc_target_o`=`branch_target_i`, `IFID_clean_o`=1, `IDEX_clean_o`=1.
  - `lock_o`=0; this overrides `stallreq_id`.
  - `flush_cnt_o`+1.
- State IDLE, accepted branch with `stallreq_if`=1:
  - Latch the target into `pend_target`.
  - Assert both cleans this cycle; `lock_o`=5'b00001.
  - Go to PEND; `flush_cnt_o`+1.
- State PEND:
  - `IFID_clean_o`=1 every cycle, so the wrong-path fetch is discarded.
  - `lock_o[0]`=1 while `stallreq_if`=1, OR'd with any ex/mem lock pattern.
  - When `stallreq_if`=0, `stallreq_ex`=0 and `stallreq_mem`=0: `pc_redirect_o`=1, `pc_target_o`=`pend_target`, `lock_o`=0, next state IDLE.
  - A downstream stall keeps the state in PEND.
  - `branch_i` is ignored in PEND; it is illegal, so the bench flags it.
- `pc_target_o`=0 whenever `pc_redirect_o`=0.
- Counters:
  - Both counters are registered and saturate at all-ones.
  - `stall_cnt_o` increments on every cycle where `lock_o[0]`=1 (including PEND).

## Timing
- `lock_o`, the cleans, `pc_redirect_o` and `pc_target_o` are combinational from the inputs and state. The consuming registers act on them at the next rising edge.
- Branch redirect in IDLE with no IF stall takes zero cycles: the PC loads the target at the same edge that flushes IF/ID and ID/EX.
- Branch during a fetch stall: the redirect fires in the first cycle after `stallreq_if` falls with no ex/mem stall. `pending_o` is high from the edge after acceptance until the edge after the redirect.
- Counter updates are visible one cycle after the qualifying cycle.
- Reset (`rst`=1 at an edge): state IDLE, `pend_target`=0, both counters 0.
  - While `rst`=1, all outputs are forced to 0.
  - A reset during PEND drops the held redirect.

## Test plan
- Stall priority: `stallreq_id`=1 and `stallreq_mem`=1 together → `lock_o`=5'b01111, `IDEX_clean_o`=0; with `stallreq_id` alone → 5'b00011, `IDEX_clean_o`=1.
- Immediate redirect: IDLE, `branch_i`=1, target 32'h0000_1040, no stalls → same cycle `pc_redirect_o`=1, `pc_target_o`=32'h1040, both cleans 1, `lock_o`=0; `flush_cnt_o`=1 next cycle.
- Pending redirect: `stallreq_if`=1 for 3 cycles, `branch_i` (target 32'h2000) in cycle 1 → `pending_o`=1 from cycle 2; `lock_o[0]`=1 through cycle 3; cycle 4 `pc_redirect_o`=1 with 32'h2000; `pending_o`=0 from cycle 5.
- Blocked branch: `branch_i`=1 with `stallreq_mem`=1 for 2 cycles → no redirect and no flush count; redirect occurs on the first cycle `stallreq_mem`=0.
- Counter saturation: preload `stall_cnt_o` near max (force), hold `stallreq_if`=1 → counter sticks at 32'hFFFF_FFFF.
- Reset mid-PEND: assert `rst` while `pending_o`=1 → next cycle IDLE, counters 0, no redirect after `rst` deasserts.
